seq_divider_hhrb98: RTL and testbench

//   Sequential restoring divider: the inverse companion of the array multiplier.

---
 rtl/seq_divider_hhrb98.sv | 102 ++++++++++
 tb/tb_seq_divider_hhrb98.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_hhrb98.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// A zero divisor takes one busy cycle, then reports all-ones quotient with div_by_zero.
module seq_divider_hhrb98 #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state;
  logic [DIVIDEND_W-1:0] dvd;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W-1:0]  part;
  logic [CNT_W-1:0]      cnt;
  logic                  zero_pend;

  logic [DIVISOR_W:0]    trial;
  logic                  fits;
  logic [DIVISOR_W-1:0]  next_rem;
  logic                  last;

  // When trial fits, the difference is below the divisor, so the low bits suffice.
  always_comb begin
    trial    = {part, dvd[DIVIDEND_W-1]};
    fits     = (trial >= {1'b0, dvs});
    next_rem = fits ? (trial[DIVISOR_W-1:0] - dvs) : trial[DIVISOR_W-1:0];
    last     = (cnt == CNT_W'(DIVIDEND_W - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dvd         <= '0;
      dvs         <= '0;
      part        <= '0;
      cnt         <= '0;
      zero_pend   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            dvd         <= dividend;
            dvs         <= divisor;
            part        <= '0;
            cnt         <= '0;
            zero_pend   <= (divisor == '0);
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (zero_pend) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            // Quotient bits shift into the vacated low end of the dividend register.
            part <= next_rem;
            dvd  <= {dvd[DIVIDEND_W-2:0], fits};
            cnt  <= cnt + CNT_W'(1);
            if (last) begin
              quotient  <= {dvd[DIVIDEND_W-2:0], fits};
              remainder <= next_rem;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_hhrb98.sv
// Scoreboard bench for seq_divider_hhrb98: expected results queued at issue, popped on done.
module tb_seq_divider_hhrb98;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  exp_t sb[$];

  seq_divider_hhrb98 dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = 8'hFF; e.r = 4'd0; e.dz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Returns at the falling edge after the accepting rising edge.
  task automatic issue(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // cyc = rising edges after the accept edge until done is seen.
  task automatic wait_done(output int cyc, output int busy_cyc, output bit ok);
    cyc = 0; busy_cyc = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (busy === 1'b1) busy_cyc++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %b required 0", {busy, done, div_by_zero, quotient, remainder});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [7:0] as [3] = '{8'd200, 8'd255, 8'd5};
    logic [3:0] bs [3] = '{4'd7, 4'd15, 4'd9};
    int cyc, bcyc;
    bit ok;
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      sb.push_back(model(as[k], bs[k]));
      issue(as[k], bs[k]);
      wait_done(cyc, bcyc, ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL basic_timeout %0d/%0d: no done", as[k], bs[k]); end
      n_checks++;
      if (cyc != 8) begin n_fail++; $display("FAIL basic_latency: got %0d required 8", cyc); end
      n_checks++;
      if (bcyc != 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d required 8", bcyc); end
      n_checks++;
      if ({quotient, remainder, div_by_zero} !== e) begin
        n_fail++;
        $display("FAIL basic_result %0d/%0d: got q=%0d r=%0d dz=%0d required q=%0d r=%0d dz=%0d",
                 as[k], bs[k], quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || quotient !== e.q || remainder !== e.r) begin
        n_fail++;
        $display("FAIL basic_hold: got done=%0d q=%0d r=%0d required done=0 q=%0d r=%0d",
                 done, quotient, remainder, e.q, e.r);
      end
    end
  endtask

  task automatic test_div_zero;
    int cyc, bcyc;
    bit ok;
    exp_t e;
    sb.push_back(model(8'd100, 4'd0));
    issue(8'd100, 4'd0);
    wait_done(cyc, bcyc, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || cyc != 1) begin n_fail++; $display("FAIL dz_latency: got %0d ok=%0d required 1", cyc, ok); end
    n_checks++;
    if ({quotient, remainder, div_by_zero} !== e) begin
      n_fail++;
      $display("FAIL dz_result: got q=%0d r=%0d dz=%0d required q=%0d r=%0d dz=%0d",
               quotient, remainder, div_by_zero, e.q, e.r, e.dz);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dz_hold: got done=%0d dz=%0d required done=0 dz=1", done, div_by_zero);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, bcyc;
    bit ok;
    exp_t e;
    sb.push_back(model(8'd90, 4'd4));
    issue(8'd90, 4'd4);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 8'd10; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0; dividend = 8'd0; divisor = 4'd0;
    wait_done(cyc, bcyc, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || cyc + 3 != 8) begin n_fail++; $display("FAIL ignore_latency: got %0d required 8", cyc + 3); end
    n_checks++;
    if ({quotient, remainder, div_by_zero} !== e) begin
      n_fail++;
      $display("FAIL ignore_result: got q=%0d r=%0d required q=%0d r=%0d", quotient, remainder, e.q, e.r);
    end
    // Issue while done is high: accepted from DONE.
    sb.push_back(model(8'd10, 4'd3));
    start = 1'b1; dividend = 8'd10; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: got done=%0d busy=%0d required done=0 busy=1", done, busy);
    end
    wait_done(cyc, bcyc, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || cyc != 8) begin n_fail++; $display("FAIL b2b_latency: got %0d required 8", cyc); end
    n_checks++;
    if ({quotient, remainder, div_by_zero} !== e) begin
      n_fail++;
      $display("FAIL b2b_result: got q=%0d r=%0d required q=%0d r=%0d", quotient, remainder, e.q, e.r);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, bcyc;
    bit ok;
    exp_t e;
    sb.push_back(model(8'd100, 4'd0));
    issue(8'd100, 4'd0);
    wait_done(cyc, bcyc, ok);
    e = sb.pop_front();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got %b required 0 (held q=%0d)", {busy, done, div_by_zero, quotient, remainder}, e.q);
    end
    @(negedge clk);
    rst = 1'b0;
    issue(8'd200, 4'd7);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got %b required 0", {busy, done, div_by_zero, quotient, remainder});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stays_idle: got done=%0d busy=%0d required 0 0", done, busy);
    end
    sb.push_back(model(8'd49, 4'd7));
    issue(8'd49, 4'd7);
    wait_done(cyc, bcyc, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || {quotient, remainder, div_by_zero} !== e || e.q != 8'd7) begin
      n_fail++;
      $display("FAIL after_reset: got q=%0d r=%0d ok=%0d required q=7 r=0", quotient, remainder, ok);
    end
  endtask

  task automatic test_sweep;
    int cyc, bcyc;
    bit ok;
    exp_t e;
    for (int b = 1; b < 16; b++) begin
      for (int a = 0; a < 256; a++) begin
        sb.push_back(model(a[7:0], b[3:0]));
        issue(a[7:0], b[3:0]);
        wait_done(cyc, bcyc, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || cyc != 8 || {quotient, remainder, div_by_zero} !== e) begin
          n_fail++;
          $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dz=%0d lat=%0d required q=%0d r=%0d dz=0 lat=8",
                   a, b, quotient, remainder, div_by_zero, cyc, e.q, e.r);
        end
      end
    end
  endtask

  task automatic test_round_trip;
    int cyc, bcyc;
    bit ok;
    int a, b;
    logic [7:0] p;
    for (int k = 0; k < 40; k++) begin
      b = $urandom_range(15, 1);
      a = $urandom_range(255 / b, 0);
      p = 8'(a * b);
      sb.push_back('{q: a[7:0], r: 4'd0, dz: 1'b0});
      issue(p, b[3:0]);
      wait_done(cyc, bcyc, ok);
      n_checks++;
      if (!ok || {quotient, remainder, div_by_zero} !== sb.pop_front()) begin
        n_fail++;
        $display("FAIL round_trip %0d*%0d: got q=%0d r=%0d required q=%0d r=0", a, b, quotient, remainder, a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    test_round_trip();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
